// File: rtl/stream_pkg.sv
// rtl/stream_pkg.sv - shared types for the stream selector
package stream_pkg;

  typedef enum logic {
    MODE_FIXED = 1'b0,
    MODE_RR    = 1'b1
  } mux_mode_t;

endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - combinational rotating-priority arbiter
module rr_arbiter #(
  parameter  int N  = 8,
  localparam int SW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [SW-1:0] ptr,
  output logic          gnt_valid,
  output logic [SW-1:0] gnt_idx
);

  logic [2*N-1:0] w_req2;
  logic [SW-1:0]  w_off;
  logic [SW:0]    w_sum;

  // Rotate so the request at ptr lands at bit 0; lowest set bit is the winner.
  assign w_req2 = {req, req} >> ptr;

  always_comb begin
    gnt_valid = 1'b0;
    w_off     = '0;
    for (int k = N - 1; k >= 0; k--) begin
      if (w_req2[k]) begin
        gnt_valid = 1'b1;
        w_off     = SW'(k);
      end
    end
    w_sum   = {1'b0, ptr} + {1'b0, w_off};
    gnt_idx = (w_sum >= (SW+1)'(N)) ? SW'(w_sum - (SW+1)'(N)) : w_sum[SW-1:0];
  end

endmodule

// File: rtl/stream_mux_rr.sv
// rtl/stream_mux_rr.sv - N-channel stream selector, fixed or round-robin, registered output
module stream_mux_rr
  import stream_pkg::*;
#(
  parameter  int N  = 8,
  parameter  int W  = 4,
  localparam int SW = $clog2(N)
) (
  input  logic                clk,
  input  logic                reset,
  input  mux_mode_t           mode,
  input  logic [SW-1:0]       sel,
  input  logic [N-1:0][W-1:0] in_data,
  input  logic [N-1:0]        in_valid,
  output logic [N-1:0]        in_ready,
  output logic [W-1:0]        out_data,
  output logic [SW-1:0]       out_chan,
  output logic                out_valid,
  input  logic                out_ready
);

  logic [W-1:0]  r_out_data;
  logic [SW-1:0] r_out_chan;
  logic          r_out_valid;
  logic [SW-1:0] r_rr_ptr;

  logic          w_load_en;
  logic          w_rr_valid;
  logic [SW-1:0] w_rr_idx;
  logic          w_fix_valid;
  logic          w_gnt_valid;
  logic [SW-1:0] w_gnt_idx;
  logic [W-1:0]  w_gnt_data;
  logic          w_xfer_in;
  logic [SW-1:0] w_ptr_next;

  rr_arbiter #(.N(N)) u_arb (
    .req       (in_valid),
    .ptr       (r_rr_ptr),
    .gnt_valid (w_rr_valid),
    .gnt_idx   (w_rr_idx)
  );

  // A sel value of N or above matches no channel, so it never grants.
  always_comb begin
    w_fix_valid = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (sel == SW'(i) && in_valid[i]) w_fix_valid = 1'b1;
    end
  end

  assign w_load_en   = !r_out_valid || out_ready;
  assign w_gnt_valid = (mode == MODE_RR) ? w_rr_valid : w_fix_valid;
  assign w_gnt_idx   = (mode == MODE_RR) ? w_rr_idx : sel;
  assign w_xfer_in   = !reset && w_load_en && w_gnt_valid;
  assign w_ptr_next  = (w_gnt_idx == SW'(N - 1)) ? '0 : w_gnt_idx + SW'(1);

  always_comb begin
    in_ready   = '0;
    w_gnt_data = '0;
    for (int i = 0; i < N; i++) begin
      if (w_gnt_idx == SW'(i)) begin
        in_ready[i] = w_xfer_in;
        w_gnt_data  = in_data[i];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_chan  <= '0;
      r_rr_ptr    <= '0;
    end else if (w_xfer_in) begin
      r_out_valid <= 1'b1;
      r_out_data  <= w_gnt_data;
      r_out_chan  <= w_gnt_idx;
      if (mode == MODE_RR) r_rr_ptr <= w_ptr_next;
    end else if (r_out_valid && out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

  assign out_data  = r_out_data;
  assign out_chan  = r_out_chan;
  assign out_valid = r_out_valid;

endmodule

// File: tb/tb_stream_mux_rr.sv
// tb/tb_stream_mux_rr.sv - directed vector bench for stream_mux_rr (N=8 and N=5)
module tb_stream_mux_rr;
  import stream_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic            reset8, out_ready8, out_valid8;
  mux_mode_t       mode8;
  logic [2:0]      sel8, out_chan8;
  logic [7:0][3:0] in_data8;
  logic [7:0]      in_valid8, in_ready8;
  logic [3:0]      out_data8;

  logic            reset5, out_ready5, out_valid5;
  mux_mode_t       mode5;
  logic [2:0]      sel5, out_chan5;
  logic [4:0][3:0] in_data5;
  logic [4:0]      in_valid5, in_ready5;
  logic [3:0]      out_data5;

  stream_mux_rr #(.N(8), .W(4)) dut8 (
    .clk(clk), .reset(reset8), .mode(mode8), .sel(sel8),
    .in_data(in_data8), .in_valid(in_valid8), .in_ready(in_ready8),
    .out_data(out_data8), .out_chan(out_chan8), .out_valid(out_valid8),
    .out_ready(out_ready8)
  );

  stream_mux_rr #(.N(5), .W(4)) dut5 (
    .clk(clk), .reset(reset5), .mode(mode5), .sel(sel5),
    .in_data(in_data5), .in_valid(in_valid5), .in_ready(in_ready5),
    .out_data(out_data5), .out_chan(out_chan5), .out_valid(out_valid5),
    .out_ready(out_ready5)
  );

  typedef struct {
    logic       rst;
    logic       md;
    logic [2:0] sel;
    logic [7:0] valid;
    logic       ordy;
    logic [7:0] exp_rdy;
    logic       exp_ov;
    logic [3:0] exp_data;
    logic [2:0] exp_chan;
  } vec_t;

  int n_pass  = 0;
  int n_total = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  // Inputs applied 1 time unit after a rising edge; in_ready checked 1 unit later,
  // registered outputs checked 1 unit after the next rising edge.
  task automatic run8(input vec_t v, input string tag);
    reset8     = v.rst;
    mode8      = mux_mode_t'(v.md);
    sel8       = v.sel;
    in_valid8  = v.valid;
    out_ready8 = v.ordy;
    #1;
    chk({tag, " in_ready"}, 32'(in_ready8), 32'(v.exp_rdy));
    @(posedge clk); #1;
    chk({tag, " out_valid"}, 32'(out_valid8), 32'(v.exp_ov));
    chk({tag, " out_data"},  32'(out_data8),  32'(v.exp_data));
    chk({tag, " out_chan"},  32'(out_chan8),  32'(v.exp_chan));
  endtask

  task automatic run5(input vec_t v, input string tag);
    reset5     = v.rst;
    mode5      = mux_mode_t'(v.md);
    sel5       = v.sel;
    in_valid5  = v.valid[4:0];
    out_ready5 = v.ordy;
    #1;
    chk({tag, " in_ready"}, 32'(in_ready5), 32'(v.exp_rdy));
    @(posedge clk); #1;
    chk({tag, " out_valid"}, 32'(out_valid5), 32'(v.exp_ov));
    chk({tag, " out_data"},  32'(out_data5),  32'(v.exp_data));
    chk({tag, " out_chan"},  32'(out_chan5),  32'(v.exp_chan));
    chk({tag, " rr_ptr<=4"}, 32'(dut5.r_rr_ptr <= 3'd4), 32'd1);
  endtask

  vec_t tbl[$];
  vec_t t5[$];

  initial begin
    in_data8   = {4'hC, 4'hA, 4'hC, 4'h7, 4'hB, 4'hD, 4'hE, 4'hF};
    in_data5   = {4'h9, 4'h8, 4'h3, 4'h2, 4'h1};
    reset8     = 1'b1; mode8 = MODE_RR; sel8 = '0; in_valid8 = 8'hFF; out_ready8 = 1'b1;
    reset5     = 1'b1; mode5 = MODE_RR; sel5 = '0; in_valid5 = '0;    out_ready5 = 1'b1;

    //        rst md sel valid  ordy rdy    ov data  chan
    tbl.push_back('{1, 1, 0, 8'hFF, 1, 8'h00, 0, 4'h0, 0}); // reset
    tbl.push_back('{1, 1, 0, 8'hFF, 1, 8'h00, 0, 4'h0, 0});
    tbl.push_back('{0, 1, 0, 8'hFF, 1, 8'h01, 1, 4'hF, 0}); // release
    tbl.push_back('{0, 0, 0, 8'hFF, 1, 8'h01, 1, 4'hF, 0}); // fixed sel 0
    tbl.push_back('{0, 0, 6, 8'hFF, 1, 8'h40, 1, 4'hA, 6});
    tbl.push_back('{0, 0, 2, 8'hFF, 1, 8'h04, 1, 4'hD, 2});
    tbl.push_back('{1, 1, 0, 8'hFF, 1, 8'h00, 0, 4'h0, 0}); // reset before fairness
    tbl.push_back('{0, 1, 0, 8'hFF, 1, 8'h01, 1, 4'hF, 0});
    tbl.push_back('{0, 1, 0, 8'hFF, 1, 8'h02, 1, 4'hE, 1});
    tbl.push_back('{0, 1, 0, 8'hFF, 1, 8'h04, 1, 4'hD, 2});
    tbl.push_back('{0, 1, 0, 8'hFF, 1, 8'h08, 1, 4'hB, 3});
    tbl.push_back('{0, 1, 0, 8'hFF, 1, 8'h10, 1, 4'h7, 4});
    tbl.push_back('{0, 1, 0, 8'hFF, 1, 8'h20, 1, 4'hC, 5});
    tbl.push_back('{0, 1, 0, 8'hFF, 1, 8'h40, 1, 4'hA, 6});
    tbl.push_back('{0, 1, 0, 8'hFF, 1, 8'h80, 1, 4'hC, 7});
    tbl.push_back('{0, 1, 0, 8'hFF, 1, 8'h01, 1, 4'hF, 0}); // wrap
    tbl.push_back('{0, 1, 0, 8'h84, 1, 8'h04, 1, 4'hD, 2}); // sparse 2/7
    tbl.push_back('{0, 1, 0, 8'h84, 1, 8'h80, 1, 4'hC, 7});
    tbl.push_back('{0, 1, 0, 8'h84, 1, 8'h04, 1, 4'hD, 2});
    tbl.push_back('{0, 1, 0, 8'h84, 1, 8'h80, 1, 4'hC, 7});
    tbl.push_back('{0, 0, 5, 8'hFF, 1, 8'h20, 1, 4'hC, 5}); // fixed leaves rr_ptr at 0
    tbl.push_back('{0, 1, 0, 8'hFF, 1, 8'h01, 1, 4'hF, 0}); // RR resumes at 0
    tbl.push_back('{0, 1, 0, 8'hFF, 0, 8'h00, 1, 4'hF, 0}); // stall
    tbl.push_back('{0, 1, 0, 8'h00, 1, 8'h00, 0, 4'hF, 0}); // drain, data kept
    tbl.push_back('{0, 1, 0, 8'h00, 0, 8'h00, 0, 4'hF, 0});

    for (int i = 0; i < tbl.size(); i++) run8(tbl[i], $sformatf("v%0d", i));

    // Backpressure: rr_ptr is 1, only ch3 valid loads the ch3 word.
    run8('{0, 1, 0, 8'h08, 1, 8'h08, 1, 4'hB, 3}, "bp_load");
    for (int k = 0; k < 4; k++) begin
      in_data8[3] = (k % 2 == 0) ? 4'h5 : 4'h0;
      run8('{0, 1, 0, 8'hFF, 0, 8'h00, 1, 4'hB, 3}, $sformatf("bp_hold%0d", k));
    end
    in_data8[3] = 4'hB;
    run8('{0, 1, 0, 8'hFF, 1, 8'h10, 1, 4'h7, 4}, "bp_release");

    // Reset while a word is held.
    run8('{0, 1, 0, 8'hFF, 0, 8'h00, 1, 4'h7, 4}, "mr_hold");
    run8('{1, 1, 0, 8'hFF, 0, 8'h00, 0, 4'h0, 0}, "mr_reset");
    run8('{0, 1, 0, 8'hFF, 1, 8'h01, 1, 4'hF, 0}, "mr_restart");

    // N=5: wrap from ch4 to ch0 and out-of-range fixed select.
    t5.push_back('{1, 1, 0, 8'h11, 1, 8'h00, 0, 4'h0, 0});
    t5.push_back('{0, 1, 0, 8'h11, 1, 8'h01, 1, 4'h1, 0});
    t5.push_back('{0, 1, 0, 8'h11, 1, 8'h10, 1, 4'h9, 4});
    t5.push_back('{0, 1, 0, 8'h11, 1, 8'h01, 1, 4'h1, 0});
    t5.push_back('{0, 1, 0, 8'h11, 1, 8'h10, 1, 4'h9, 4});
    t5.push_back('{0, 0, 6, 8'h1F, 1, 8'h00, 0, 4'h9, 4});
    t5.push_back('{0, 0, 6, 8'h1F, 1, 8'h00, 0, 4'h9, 4});
    t5.push_back('{0, 0, 4, 8'h1F, 1, 8'h10, 1, 4'h9, 4});
    t5.push_back('{0, 1, 0, 8'h1F, 1, 8'h01, 1, 4'h1, 0});
    for (int i = 0; i < t5.size(); i++) run5(t5[i], $sformatf("n5_v%0d", i));

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
